ready_valid_rr_arbiter: RTL and testbench
=========================================

// Module: ready_valid_rr_arbiter
// PURPOSE
//  N-to-1 round-robin arbiter multiplexing ready_valid_i streams onto one shared consumer.
//  Once granted, an input keeps the output for up to MAX_BURST beats, so bursts stay contiguous.
//  Counterpart to the duplicator/combiner helpers: it schedules access to a shared stream sink
//  (e.g. a single memory or host write port) among several producers.
// PARAMETERS
//  NUM_INPUTS  4   number of requesting streams, >=1
//  MAX_BURST   16  max consecutive beats granted to one input before forced re-arbitration, >=1
//  (data_t is carried by the interfaces; all inputs and the output share one data_t)
// PORTS
//  clk          in   1                 clock
//  rst_n        in   1                 reset, synchronous, active-low
//  in[NUM_INPUTS] ready_valid_i.s  data_t  requester streams
//  out          ready_valid_i.m    data_t  arbitrated stream
//  grant_id     out  GRANT_W           index of the currently owning input; GRANT_W = max(1,$clog2(NUM_INPUTS))
//  grant_valid  out  1                 1 while an input owns the output (state LOCKED or IDLE-select with valid)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, beat_cnt=0; while rst_n low: out.valid=0, all in[i].ready=0,
//   grant_valid=0, grant_id=0.
//  State IDLE: combinational select sel = first i with in[i].valid, searching rr_ptr, rr_ptr+1, ... wrapping mod NUM_INPUTS.
//   - No input valid: out.valid=0, all in.ready=0, grant_valid=0; state unchanged.
//   - Else out.data=in[sel].data, out.valid=1, in[sel].ready=out.ready, others ready=0; zero latency.
//   - Handshake with MAX_BURST==1: stay IDLE, rr_ptr<=sel+1 (wrap).
//   - Otherwise: grant<=sel, state<=LOCKED, beat_cnt<=(handshake ? 1 : 0).
//  State LOCKED: only in[grant] is routed; all other in.ready=0.
//   - Handshake: beat_cnt++; if beat_cnt+1==MAX_BURST -> IDLE, rr_ptr<=grant+1, beat_cnt<=0.
//   - in[grant].valid==0 (no beat offered): release -> IDLE, rr_ptr<=grant+1, beat_cnt<=0;
//     out.valid=0 that cycle; new arbitration in the next cycle.
//   - out.valid && !out.ready: grant, data and count held (valid must not retract, grant must not move).
//  Fairness: with all inputs continuously valid, each gets exactly MAX_BURST beats in turn, order 0,1,..,N-1.
//  A released input is lowest priority on the next arbitration, even if it is still valid.
//  beat_cnt width $clog2(MAX_BURST+1); never exceeds MAX_BURST-1 when registered.
//  Reset mid-burst: burst abandoned, no partial accounting; upstream resends per its own protocol.
//  NUM_INPUTS==1: degenerates to pass-through with burst counting; grant_id constant 0.
// CONFIGURATION
//  RV_ARB_OUT_REG_EN defined: arbiter output passes through a 2-entry skid buffer before `out`.
//   +1 cycle latency, full throughput.
//   Arbitration uses the skid buffer's input ready; no combinational path from out.ready to in.ready.
//   Skid buffer empties on reset (out.valid=0).
//   grant_id/grant_valid reflect the arbiter stage, not the beat currently on `out`.
//  Undefined: purely combinational data/valid/ready path, zero latency as described above.
// STRUCTURE
//  Package rv_arb_pkg: typedef enum logic {IDLE, LOCKED} rv_arb_state_t;
//   function grant_width(n) = max(1,$clog2(n)).
//  Sub-module ready_valid_skid_buffer (ready_valid_i.s in, ready_valid_i.m out, clk, rst_n).
//   Instantiated only under RV_ARB_OUT_REG_EN; reusable elsewhere.
//  Priority select implemented as rotate-by-rr_ptr, find-first-set, rotate back.
// TESTING
//  1. N=4, B=4, all valid, out.ready=1: out sequence 4 beats from in0, 4 from in1, 4 from in2, 4 from in3, 4 from in0.
//  2. N=4, B=4, only in2 valid for 10 beats: 4 beats from in2, then re-grant to in2 (rr_ptr=3, wraps); 10 beats, no gaps except 0.
//  3. in1 valid for 2 beats then drops, in3 valid: 2 beats from in1, 1 idle cycle, then in3 granted; grant_id 1 -> 3.
//  4. out.ready=0 for 5 cycles with in0 and in1 valid: out.valid=1, data=in0.data stable, grant_id=0 held, in1.ready=0 throughout.
//  5. Assert rst_n=0 mid-burst (beat 2 of 4): next cycle out.valid=0, all in.ready=0; after release, arbitration restarts at in0.
//  6. With RV_ARB_OUT_REG_EN: repeat test 1: identical beat order shifted by 1 cycle; no bubbles under continuous ready.

Source files
------------

// File: rtl/ready_valid_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rv_arb_pkg
// Shared types and helpers for the ready/valid round-robin arbiter slice.
//   rv_arb_state_t : arbiter FSM state (IDLE = free to arbitrate,
//                    LOCKED = one input owns the output for a burst)
//   grant_width(n) : width of a grant index for n requesters, at least 1 bit
// ----------------------------------------------------------------------------
package rv_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } rv_arb_state_t;

    // A single requester still needs a 1-bit grant index.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ready_valid_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// ready_valid_i
// Single ready/valid stream carrying DATA_W-bit beats.
//   valid : producer offers a beat
//   ready : consumer accepts it (a beat moves when valid && ready)
//   data  : beat payload, stable while valid && !ready
// Modports:
//   m : producer side (drives valid/data, samples ready)
//   s : consumer side (samples valid/data, drives ready)
// ----------------------------------------------------------------------------
interface ready_valid_i #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport m (output valid, output data, input ready);
    modport s (input valid, input data, output ready);
endinterface

// File: rtl/ready_valid_rr_arbiter_skid_buffer.sv
// ----------------------------------------------------------------------------
// ready_valid_skid_buffer
// Two-entry ready/valid register slice. Full throughput, one cycle latency,
// and in_i.ready depends only on local state, so there is no combinational
// path from out_o.ready back to in_i.ready.
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset; empties both entries, and
//            out_o.valid / in_i.ready read 0 while it is low
//   in_i   : upstream stream (consumer side)
//   out_o  : downstream stream (producer side)
// ----------------------------------------------------------------------------
module ready_valid_skid_buffer #(
    parameter int DATA_W = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    ready_valid_i.s in_i,
    ready_valid_i.m out_o
);

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic              in_ready_s, out_valid_s, in_hs_s, out_hs_s;

    // Accept only while the overflow entry is free; it absorbs the beat that
    // arrives in the same cycle the consumer stalls.
    assign in_ready_s  = rst_n && !skid_valid_q;
    assign out_valid_s = rst_n && main_valid_q;
    assign in_hs_s     = in_i.valid && in_ready_s;
    assign out_hs_s    = out_valid_s && out_o.ready;

    assign in_i.ready  = in_ready_s;
    assign out_o.valid = out_valid_s;
    assign out_o.data  = main_data_q;

    // Next-state: refill the output entry from the overflow entry first, then
    // from the input; park the input in the overflow entry on a stall.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_hs_s || !main_valid_q) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_hs_s) begin
                main_valid_d = 1'b1;
                main_data_d  = in_i.data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else begin
            if (in_hs_s) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_i.data;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= {DATA_W{1'b0}};
            skid_data_q  <= {DATA_W{1'b0}};
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/ready_valid_rr_arbiter.sv
// ----------------------------------------------------------------------------
// ready_valid_rr_arbiter
// N-to-1 round-robin arbiter over ready/valid streams. An input that wins
// keeps the output for up to MAX_BURST consecutive beats; it is released
// early if it stops offering a beat. A released input becomes lowest
// priority for the next arbitration.
// Parameters:
//   NUM_INPUTS : number of requesters (>= 1)
//   MAX_BURST  : beats per grant before forced re-arbitration (>= 1)
//   DATA_W     : payload width, must match the connected interfaces
// Ports:
//   clk           : clock
//   rst_n         : synchronous active-low reset; while low all in ready,
//                   out valid, grant_valid_o and grant_id_o read 0
//   in_i[]        : requester streams (consumer side)
//   out_o         : arbitrated stream (producer side)
//   grant_id_o    : index of the input owning the arbiter stage
//   grant_valid_o : an input currently owns the arbiter stage
// Build option:
//   RV_ARB_OUT_REG_EN : insert ready_valid_skid_buffer between the arbiter
//   stage and out_o (+1 cycle latency, full throughput, arbitration driven
//   by the buffer's ready). grant_id_o/grant_valid_o then describe the
//   arbiter stage, not the beat on out_o. Undefined: zero-latency
//   combinational data/valid/ready path.
// ----------------------------------------------------------------------------
module ready_valid_rr_arbiter
    import rv_arb_pkg::*;
#(
    parameter  int NUM_INPUTS = 4,
    parameter  int MAX_BURST  = 16,
    parameter  int DATA_W     = 8,
    localparam int GRANT_W    = grant_width(NUM_INPUTS)
) (
    input  logic               clk,
    input  logic               rst_n,
    ready_valid_i.s            in_i [NUM_INPUTS],
    ready_valid_i.m            out_o,
    output logic [GRANT_W-1:0] grant_id_o,
    output logic               grant_valid_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    rv_arb_state_t     state_q, state_d;
    logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic [NUM_INPUTS-1:0] in_valid_s;
    logic [DATA_W-1:0]     in_data_s [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] in_ready_s;

    logic [NUM_INPUTS-1:0] rot_valid_s;
    logic [GRANT_W-1:0]    ffs_s;
    logic                  sel_found_s;
    logic [GRANT_W-1:0]    sel_s;

    logic               arb_valid_s;
    logic [DATA_W-1:0]  arb_data_s;
    logic               arb_ready_s;
    logic               grant_valid_s;
    logic [GRANT_W-1:0] grant_id_s;

    // (base + off) mod NUM_INPUTS, for base < NUM_INPUTS and off <= NUM_INPUTS.
    function automatic logic [GRANT_W-1:0] wrap_add(input logic [GRANT_W-1:0] base,
                                                    input int off);
        int sum;
        sum = off;
        sum = sum + int'(base);
        if (sum >= NUM_INPUTS) begin
            sum = sum - NUM_INPUTS;
        end else begin
            sum = sum;
        end
        return GRANT_W'(sum);
    endfunction

    // Flatten the interface array; interface arrays only take constant indices.
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_in
        assign in_valid_s[g] = in_i[g].valid;
        assign in_data_s[g]  = in_i[g].data;
        assign in_i[g].ready = rst_n && in_ready_s[g];
    end

    // Priority select: rotate so rr_ptr is bit 0, take the lowest set bit,
    // then rotate the index back.
    always_comb begin
        rot_valid_s = {NUM_INPUTS{1'b0}};
        ffs_s       = {GRANT_W{1'b0}};
        sel_found_s = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            rot_valid_s[k] = in_valid_s[wrap_add(rr_ptr_q, k)];
        end
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            if (rot_valid_s[k]) begin
                ffs_s       = GRANT_W'(k);
                sel_found_s = 1'b1;
            end else begin
                ffs_s = ffs_s;
            end
        end
        sel_s = wrap_add(rr_ptr_q, int'(ffs_s));
    end

    // Routing and FSM next-state.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        beat_cnt_d    = beat_cnt_q;
        arb_valid_s   = 1'b0;
        arb_data_s    = {DATA_W{1'b0}};
        in_ready_s    = {NUM_INPUTS{1'b0}};
        grant_valid_s = 1'b0;
        grant_id_s    = {GRANT_W{1'b0}};
        case (state_q)
            IDLE: begin
                if (sel_found_s) begin
                    arb_valid_s       = 1'b1;
                    arb_data_s        = in_data_s[sel_s];
                    in_ready_s[sel_s] = arb_ready_s;
                    grant_valid_s     = 1'b1;
                    grant_id_s        = sel_s;
                    if (arb_ready_s && (MAX_BURST == 1)) begin
                        // Single-beat bursts never need the LOCKED state.
                        rr_ptr_d = wrap_add(sel_s, 1);
                    end else begin
                        grant_d    = sel_s;
                        state_d    = LOCKED;
                        beat_cnt_d = arb_ready_s ? CNT_W'(1) : {CNT_W{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                grant_valid_s = 1'b1;
                grant_id_s    = grant_q;
                if (in_valid_s[grant_q]) begin
                    arb_valid_s         = 1'b1;
                    arb_data_s          = in_data_s[grant_q];
                    in_ready_s[grant_q] = arb_ready_s;
                    if (arb_ready_s) begin
                        if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                            state_d    = IDLE;
                            rr_ptr_d   = wrap_add(grant_q, 1);
                            beat_cnt_d = {CNT_W{1'b0}};
                        end else begin
                            beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        // Stalled: valid stays up, grant and count hold.
                        beat_cnt_d = beat_cnt_q;
                    end
                end else begin
                    // Owner has nothing to send: give the output up now.
                    state_d    = IDLE;
                    rr_ptr_d   = wrap_add(grant_q, 1);
                    beat_cnt_d = {CNT_W{1'b0}};
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state, round-robin pointer, owner and burst count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= {GRANT_W{1'b0}};
            grant_q    <= {GRANT_W{1'b0}};
            beat_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant_valid_o = rst_n && grant_valid_s;
    assign grant_id_o    = rst_n ? grant_id_s : {GRANT_W{1'b0}};

`ifdef RV_ARB_OUT_REG_EN
    ready_valid_i #(.DATA_W(DATA_W)) arb_if ();

    assign arb_if.valid = rst_n && arb_valid_s;
    assign arb_if.data  = arb_data_s;
    assign arb_ready_s  = arb_if.ready;

    ready_valid_skid_buffer #(
        .DATA_W (DATA_W)
    ) u_out_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .in_i  (arb_if),
        .out_o (out_o)
    );
`else
    assign out_o.valid = rst_n && arb_valid_s;
    assign out_o.data  = arb_data_s;
    assign arb_ready_s = out_o.ready;
`endif

endmodule

// File: tb/tb_ready_valid_rr_arbiter.sv
module tb_ready_valid_rr_arbiter;

`ifdef RV_ARB_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       out_ready;
    logic [1:0] grant_id;
    logic       grant_valid;

    logic [3:0] drv_valid;
    logic [7:0] drv_data [4];
    logic [3:0] mon_ready;
    logic [3:0] hs_in;

    int         budget  [4];
    logic [5:0] drv_cnt [4];
    logic [5:0] exp_cnt [4];
    logic [7:0] exp_q [$];

    int n_cmp;
    int n_err;
    int cyc;

    ready_valid_i #(.DATA_W(8)) in_if [4] ();
    ready_valid_i #(.DATA_W(8)) out_if ();

    for (genvar g = 0; g < 4; g++) begin : g_drv
        assign in_if[g].valid = drv_valid[g];
        assign in_if[g].data  = drv_data[g];
        assign mon_ready[g]   = in_if[g].ready;
    end
    assign out_if.ready = out_ready;

    ready_valid_rr_arbiter #(
        .NUM_INPUTS (4),
        .MAX_BURST  (4),
        .DATA_W     (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_i          (in_if),
        .out_o         (out_if),
        .grant_id_o    (grant_id),
        .grant_valid_o (grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Producers: input i offers {i, seq} while it still has budget.
    task automatic update_drv();
        for (int i = 0; i < 4; i++) begin
            drv_valid[i] = (budget[i] != 0);
            drv_data[i]  = {2'(i), drv_cnt[i]};
        end
    endtask

    // Expected output order: n beats from src, continuing its sequence.
    task automatic push(input int src, input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({2'(src), exp_cnt[src]});
            exp_cnt[src] = exp_cnt[src] + 6'd1;
        end
    endtask

    // Sample at the falling edge: check grant on accepted inputs, score output beats.
    task automatic obs();
        @(negedge clk);
        hs_in = mon_ready & drv_valid;
        for (int i = 0; i < 4; i++) begin
            if (hs_in[i]) begin
                chk("hs_grant_id", 32'(grant_id), 32'(i));
                chk("hs_grant_valid", 32'(grant_valid), 32'd1);
            end
        end
        if (out_if.valid && out_if.ready) begin
            chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                chk("out_data", 32'(out_if.data), 32'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (hs_in[i]) begin
                budget[i]  = budget[i] - 1;
                drv_cnt[i] = drv_cnt[i] + 6'd1;
            end
        end
        update_drv();
    endtask

    task automatic drain(input string tag, input int max, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < max) begin
            obs();
            adv();
            cycles++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            obs();
            adv();
        end
    endtask

    // Called just after a rising edge; producers keep whatever valid they had.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_out_valid", 32'(out_if.valid), 32'd0);
            chk("rst_in_ready", 32'(mon_ready), 32'd0);
            chk("rst_grant_valid", 32'(grant_valid), 32'd0);
            chk("rst_grant_id", 32'(grant_id), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            budget[i]  = 0;
            drv_cnt[i] = 6'd0;
            exp_cnt[i] = 6'd0;
        end
        update_drv();
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        hs_in     = 4'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            budget[i]  = 0;
            drv_cnt[i] = 6'd0;
            exp_cnt[i] = 6'd0;
        end
        update_drv();
        do_reset();

        // 1: all inputs valid, continuous ready -> 4 beats each in order 0,1,2,3,0.
        budget[0] = 8; budget[1] = 4; budget[2] = 4; budget[3] = 4;
        update_drv();
        push(0, 4); push(1, 4); push(2, 4); push(3, 4); push(0, 4);
        drain("t1_drain", 60, cyc);
        chk("t1_cycles", 32'(cyc), 32'(20 + LAT));
        idle(3);

        // 2: only in2 valid for 10 beats -> re-granted after wrap, no gaps.
        budget[2] = 10;
        update_drv();
        push(2, 10);
        drain("t2_drain", 40, cyc);
        chk("t2_cycles", 32'(cyc), 32'(10 + LAT));
        idle(3);

        // 3: in1 two beats then drops; in3 waits -> one bubble, then in3.
        do_reset();
        budget[1] = 2; budget[3] = 3;
        update_drv();
        push(1, 2); push(3, 3);
        drain("t3_drain", 30, cyc);
        chk("t3_cycles", 32'(cyc), 32'(6 + LAT));
        idle(3);

        // 4: consumer stalls 5 cycles with in0 and in1 valid.
        do_reset();
        out_ready = 1'b0;
        budget[0] = 1; budget[1] = 1;
        update_drv();
        push(0, 1); push(1, 1);
        repeat (5) begin
            obs();
`ifndef RV_ARB_OUT_REG_EN
            chk("t4_out_valid", 32'(out_if.valid), 32'd1);
            chk("t4_out_data", 32'(out_if.data), 32'(exp_q[0]));
            chk("t4_grant_id", 32'(grant_id), 32'd0);
            chk("t4_grant_valid", 32'(grant_valid), 32'd1);
            chk("t4_in_ready", 32'(mon_ready), 32'd0);
`endif
            adv();
        end
        out_ready = 1'b1;
        drain("t4_drain", 20, cyc);
        idle(3);

        // 5: reset after two beats of an in0 burst, then arbitration restarts at in0.
        do_reset();
        budget[0] = 4;
        update_drv();
        push(0, 2);
        drain("t5_pre_drain", 20, cyc);
        do_reset();
        budget[0] = 4; budget[1] = 4; budget[2] = 4; budget[3] = 4;
        update_drv();
        push(0, 4); push(1, 4); push(2, 4); push(3, 4);
        drain("t5_drain", 60, cyc);
        chk("t5_cycles", 32'(cyc), 32'(16 + LAT));
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
